// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: streams a latched input vector to a row of serial MAC neurons and captures their results
module neuron_layer_sequencer #(
    parameter int SIZE    = 4,
    parameter int DEPTH   = 8,
    parameter int NEURONS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SIZE*DEPTH-1:0]      in_vec_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [DEPTH-1:0]           x_out_o,
    output logic                       neuron_clr_o,
    input  logic [NEURONS*DEPTH-1:0]   y_in_i,
    output logic [NEURONS*DEPTH-1:0]   out_vec_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);
    localparam int KW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                          state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [SIZE-1:0][DEPTH-1:0]      buf_q, buf_d;
    logic [DEPTH-1:0]                x_q, x_d;
    logic [NEURONS*DEPTH-1:0]        vec_q, vec_d;
    logic                            valid_q, valid_d;
    logic                            clr_q, clr_d;
    logic [KW-1:0]                   nxt_idx;
    logic                            last;
    logic                            take;

    // x_out is registered, so the element for step k+1 is fetched while step k is on the bus
    assign nxt_idx = KW'(SIZE - 2) - k_q;
    assign last    = k_q == KW'(SIZE - 1);
    assign take    = in_valid_i & in_ready_o;

    assign x_out_o      = x_q;
    assign out_vec_o    = vec_q;
    assign out_valid_o  = valid_q;
    assign neuron_clr_o = clr_q;

    // next-state, handshake and datapath control; a transfer always restarts the stream at k=0
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        buf_d      = buf_q;
        x_d        = x_q;
        vec_d      = vec_q;
        valid_d    = valid_q;
        clr_d      = clr_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = !rst;
                clr_d      = 1'b1;
                x_d        = '0;
            end
            STREAM: begin
                busy_o = 1'b1;
                if (last) begin
                    vec_d   = y_in_i;
                    valid_d = 1'b1;
                    clr_d   = 1'b1;
                    x_d     = '0;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                    x_d = buf_q[nxt_idx];
                end
            end
            DONE: begin
                in_ready_o = out_ready_i & !rst;
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            buf_d   = in_vec_i;
            k_d     = '0;
            x_d     = in_vec_i[SIZE*DEPTH-1 -: DEPTH];
            clr_d   = 1'b0;
            valid_d = 1'b0;
            state_d = STREAM;
        end
    end

    // state register; reset drops any partial stream and holds the neurons in clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            buf_q   <= '0;
            x_q     <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            x_q     <= x_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            clr_q   <= clr_d;
        end
    end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed checks of the sequencer against a behavioural falling-edge MAC neuron pair
module tb_neuron_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_vec = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  x_out;
    logic        neuron_clr;
    logic [15:0] y_in;
    logic [15:0] out_vec;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] w0 [0:3];
    logic signed [7:0] w1 [0:3];
    logic signed [7:0] acc0 = '0;
    logic signed [7:0] acc1 = '0;
    int widx = 3;

    neuron_layer_sequencer #(.SIZE(4), .DEPTH(8), .NEURONS(2)) dut (
        .clk(clk), .rst(rst),
        .in_vec_i(in_vec), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .x_out_o(x_out), .neuron_clr_o(neuron_clr), .y_in_i(y_in),
        .out_vec_o(out_vec), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign y_in = {acc1, acc0};

    function automatic logic signed [7:0] sat(input int v);
        return (v > 127) ? 8'sd127 : (v < -128) ? -8'sd128 : 8'(v);
    endfunction

    // neuron pair: clear on neuron_clr, otherwise MAC on the falling edge with weights rotating from index 3 down
    always @(negedge clk) begin
        if (neuron_clr) begin
            acc0 <= '0;
            acc1 <= '0;
            widx <= 3;
        end else begin
            acc0 <= sat(int'(acc0) + int'($signed(x_out)) * int'(w0[widx]));
            acc1 <= sat(int'(acc1) + int'($signed(x_out)) * int'(w1[widx]));
            widx <= (widx == 0) ? 3 : widx - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input logic [31:0] v, input logic [15:0] exp, input string tag);
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        step();
        step();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_vec"}, 32'(out_vec), 32'(exp));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            w0[i] = 8'sd1;
            w1[i] = 8'sd0;
        end
        w1[3] = 8'sd1;

        // reset values
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_clr", 32'(neuron_clr), 32'd1);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vec", 32'(out_vec), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // basic: x sequence 4,3,2,1 and result n1=4, n0=10
        in_vec   = 32'h04030201;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("basic_x0", 32'(x_out), 32'd4);
        chk("basic_clr", 32'(neuron_clr), 32'd0);
        chk("basic_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("basic_x1", 32'(x_out), 32'd3);
        step();
        chk("basic_x2", 32'(x_out), 32'd2);
        step();
        chk("basic_x3", 32'(x_out), 32'd1);
        chk("basic_early", 32'(out_valid), 32'd0);
        step();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_vec", 32'(out_vec), 32'h040A);
        chk("basic_done_clr", 32'(neuron_clr), 32'd1);
        chk("basic_done_x", 32'(x_out), 32'd0);

        // backpressure: everything holds while out_ready is low
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_vec", 32'(out_vec), 32'h040A);
            chk("bp_clr", 32'(neuron_clr), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_x", 32'(x_out), 32'd0);
        end
        release_out();
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // saturation both directions
        for (int i = 0; i < 4; i++) w1[i] = 8'sd1;
        run_vec(32'h7F7F7F7F, 16'h7F7F, "sat_pos");
        release_out();
        run_vec(32'h81818181, 16'h8080, "sat_neg");
        release_out();
        for (int i = 0; i < 3; i++) w1[i] = 8'sd0;

        // back-to-back with out_ready held high
        begin
            logic [31:0] vecs [0:2];
            logic [15:0] exps [0:2];
            vecs[0] = 32'h04030201; exps[0] = 16'h040A;
            vecs[1] = 32'h01020304; exps[1] = 16'h010A;
            vecs[2] = 32'hFF050007; exps[2] = 16'hFF0B;
            in_vec    = vecs[0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            chk("b2b_start_busy", 32'(busy), 32'd1);
            for (int v = 0; v < 3; v++) begin
                for (int i = 0; i < 8 && !out_valid; i++) step();
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_vec", 32'(out_vec), 32'(exps[v]));
                if (v < 2) in_vec = vecs[v + 1];
                else in_valid = 1'b0;
                step();
                chk("b2b_drop", 32'(out_valid), 32'd0);
                chk("b2b_busy", 32'(busy), (v < 2) ? 32'd1 : 32'd0);
            end
            out_ready = 1'b0;
        end

        // reset mid-stream at k=2
        in_vec   = 32'h04030201;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_x", 32'(x_out), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_clr", 32'(neuron_clr), 32'd1);
        chk("mid_rst_x", 32'(x_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        run_vec(32'h01020304, 16'h010A, "post_rst");
        release_out();

        // input stability: in_vec churns and in_valid stays high during STREAM
        in_vec   = 32'h02020202;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            in_vec = $urandom;
            chk("stab_in_ready", 32'(in_ready), 32'd0);
            chk("stab_x", 32'(x_out), 32'd2);
            step();
        end
        chk("stab_x_last", 32'(x_out), 32'd2);
        step();
        chk("stab_valid", 32'(out_valid), 32'd1);
        chk("stab_vec", 32'(out_vec), 32'h0208);
        step();
        chk("stab_hold_valid", 32'(out_valid), 32'd1);
        chk("stab_hold_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        release_out();
        chk("stab_idle_busy", 32'(busy), 32'd0);
        step();
        chk("stab_no_extra", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
